// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   src_e          : writeback source encoding (ALU pipe A, load pipe M)
//   WPORT_RST_VAL  : value loaded into write-port and buffer address/data
//                    registers on reset
package rf_wb_arbiter_pkg;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_M = 1'b1
  } src_e;

  localparam logic [31:0] WPORT_RST_VAL = 32'd0;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bus bundle between the two writeback sources, the arbiter and the
// register file write port.
//   a_valid/a_addr/a_data/a_ready : ALU writeback handshake
//   m_valid/m_addr/m_data/m_ready : load writeback handshake
//   rf_w_en/rf_w_addr/rf_w_data   : registered register-file write port
//   busy_mask                     : registers with writes still in flight
// Modports: slave = the arbiter, master = the sources / register file side.
interface rf_wb_arbiter_if #(
  parameter int DEPTH = 4,
  parameter int ADDR  = 2,
  parameter int WIDTH = 8
);
  logic             a_valid;
  logic [ADDR-1:0]  a_addr;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             m_valid;
  logic [ADDR-1:0]  m_addr;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;
  logic             rf_w_en;
  logic [ADDR-1:0]  rf_w_addr;
  logic [WIDTH-1:0] rf_w_data;
  logic [DEPTH-1:0] busy_mask;

  modport slave (
    input  a_valid, a_addr, a_data, m_valid, m_addr, m_data,
    output a_ready, m_ready, rf_w_en, rf_w_addr, rf_w_data, busy_mask
  );

  modport master (
    output a_valid, a_addr, a_data, m_valid, m_addr, m_data,
    input  a_ready, m_ready, rf_w_en, rf_w_addr, rf_w_data, busy_mask
  );
endinterface

// File: rtl/rf_wb_arbiter_hold_buf.sv
// wb_hold_buf: 1-entry writeback hold buffer.
//   clk, rst        : clock, synchronous active-high reset
//   load            : capture addr_in/data_in this edge (becomes full)
//   free            : entry drained by the arbiter this edge
//   addr_in/data_in : incoming request contents
//   full/addr/data  : buffer state
// A load wins over a free at the same edge, so a buffer drained and
// refilled together stays full with the new contents.
module wb_hold_buf #(
  parameter int ADDR  = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             free,
  input  logic [ADDR-1:0]  addr_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic [ADDR-1:0]  addr,
  output logic [WIDTH-1:0] data
);
  import rf_wb_arbiter_pkg::*;

  logic             full_reg;
  logic             full_next;
  logic [ADDR-1:0]  addr_reg;
  logic [WIDTH-1:0] data_reg;

  always_comb begin
    full_next = full_reg;
    if (load) begin
      full_next = 1'b1;
    end else if (free) begin
      full_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_reg <= 1'b0;
      addr_reg <= ADDR'(WPORT_RST_VAL);
      data_reg <= WIDTH'(WPORT_RST_VAL);
    end else begin
      full_reg <= full_next;
      if (load) begin
        addr_reg <= addr_in;
        data_reg <= data_in;
      end
    end
  end

  assign full = full_reg;
  assign addr = addr_reg;
  assign data = data_reg;
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register file's single write port between the
// ALU pipe (A) and the load pipe (M). Each source has a 1-entry hold buffer;
// an age-aware round-robin arbiter drains at most one buffer per cycle into
// registered write-port outputs.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rf_wb_arbiter_if.slave (source handshakes, write port,
//              busy_mask of registers with writes in flight)
module rf_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int ADDR  = 2,
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  rf_wb_arbiter_if.slave    bus
);
  import rf_wb_arbiter_pkg::*;

  logic             a_full, m_full;
  logic [ADDR-1:0]  a_buf_addr, m_buf_addr;
  logic [WIDTH-1:0] a_buf_data, m_buf_data;
  logic             a_ready, m_ready;
  logic             a_load, m_load;
  logic             grant_valid;
  src_e             grant_src;
  logic             a_grant, m_grant;

  src_e             last_grant_reg;
  src_e             older_reg;
  logic             rf_w_en_reg;
  logic [ADDR-1:0]  rf_w_addr_reg;
  logic [WIDTH-1:0] rf_w_data_reg;

  // Grant depends on registered state only. Same-address conflicts must
  // respect arrival order; otherwise alternate to bound the stall to one cycle.
  always_comb begin
    grant_valid = a_full | m_full;
    grant_src   = SRC_A;
    if (a_full && m_full) begin
      if (a_buf_addr == m_buf_addr) begin
        grant_src = older_reg;
      end else begin
        grant_src = (last_grant_reg == SRC_A) ? SRC_M : SRC_A;
      end
    end else if (m_full) begin
      grant_src = SRC_M;
    end
  end

  assign a_grant = grant_valid && (grant_src == SRC_A);
  assign m_grant = grant_valid && (grant_src == SRC_M);

  // Ready never looks at valid, so there is no combinational path back.
  assign a_ready = !rst && (!a_full || a_grant);
  assign m_ready = !rst && (!m_full || m_grant);
  assign a_load  = bus.a_valid && a_ready;
  assign m_load  = bus.m_valid && m_ready;

  wb_hold_buf #(.ADDR(ADDR), .WIDTH(WIDTH)) u_buf_a (
    .clk     (clk),
    .rst     (rst),
    .load    (a_load),
    .free    (a_grant),
    .addr_in (bus.a_addr),
    .data_in (bus.a_data),
    .full    (a_full),
    .addr    (a_buf_addr),
    .data    (a_buf_data)
  );

  wb_hold_buf #(.ADDR(ADDR), .WIDTH(WIDTH)) u_buf_m (
    .clk     (clk),
    .rst     (rst),
    .load    (m_load),
    .free    (m_grant),
    .addr_in (bus.m_addr),
    .data_in (bus.m_data),
    .full    (m_full),
    .addr    (m_buf_addr),
    .data    (m_buf_data)
  );

  // older_reg is only meaningful while both buffers are full. The buffer
  // loaded most recently is the younger one; a simultaneous load makes M older.
  always_ff @(posedge clk) begin
    if (rst) begin
      older_reg <= SRC_A;
    end else if (a_load) begin
      older_reg <= SRC_M;
    end else if (m_load) begin
      older_reg <= SRC_A;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= SRC_A;
      rf_w_en_reg    <= 1'b0;
      rf_w_addr_reg  <= ADDR'(WPORT_RST_VAL);
      rf_w_data_reg  <= WIDTH'(WPORT_RST_VAL);
    end else begin
      rf_w_en_reg <= grant_valid;
      if (grant_valid) begin
        last_grant_reg <= grant_src;
        rf_w_addr_reg  <= (grant_src == SRC_M) ? m_buf_addr : a_buf_addr;
        rf_w_data_reg  <= (grant_src == SRC_M) ? m_buf_data : a_buf_data;
      end
    end
  end

  // A register is busy while its write sits in either buffer or on the port.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
    assign bus.busy_mask[gi] = (a_full && (a_buf_addr == ADDR'(gi)))
                             | (m_full && (m_buf_addr == ADDR'(gi)))
                             | (rf_w_en_reg && (rf_w_addr_reg == ADDR'(gi)));
  end

  assign bus.a_ready   = a_ready;
  assign bus.m_ready   = m_ready;
  assign bus.rf_w_en   = rf_w_en_reg;
  assign bus.rf_w_addr = rf_w_addr_reg;
  assign bus.rf_w_data = rf_w_data_reg;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  rf_wb_arbiter_if #(.DEPTH(4), .ADDR(2), .WIDTH(8)) bus ();

  rf_wb_arbiter #(.DEPTH(4), .ADDR(2), .WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic single_src(input string tag);
    bus.a_valid = 1'b1; bus.a_addr = 2'd2; bus.a_data = 8'h5A;
    step();
    bus.a_valid = 1'b0;
    chk({tag, "_busy1"}, 32'(bus.busy_mask), 32'h4);
    chk({tag, "_en0"},   32'(bus.rf_w_en),   32'h0);
    step();
    chk({tag, "_en"},    32'(bus.rf_w_en),   32'h1);
    chk({tag, "_addr"},  32'(bus.rf_w_addr), 32'h2);
    chk({tag, "_data"},  32'(bus.rf_w_data), 32'h5A);
    step();
    chk({tag, "_en_off"}, 32'(bus.rf_w_en),  32'h0);
    chk({tag, "_busy0"}, 32'(bus.busy_mask), 32'h0);
    $display("single %s: A r2=5A done", tag);
  endtask

  initial begin
    logic [7:0] a_cnt, m_cnt;
    logic       acc_a, acc_m;
    int         wr;

    rst = 1'b1;
    bus.a_valid = 1'b1; bus.a_addr = 2'd0; bus.a_data = 8'h00;
    bus.m_valid = 1'b1; bus.m_addr = 2'd0; bus.m_data = 8'h00;

    // Reset held for three edges with both sources requesting.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_a_ready", 32'(bus.a_ready),   32'h0);
      chk("rst_m_ready", 32'(bus.m_ready),   32'h0);
      chk("rst_en",      32'(bus.rf_w_en),   32'h0);
      chk("rst_busy",    32'(bus.busy_mask), 32'h0);
    end
    chk("rst_addr", 32'(bus.rf_w_addr), 32'h0);
    chk("rst_data", 32'(bus.rf_w_data), 32'h0);
    rst = 1'b0;
    bus.a_valid = 1'b0; bus.m_valid = 1'b0;
    step();
    chk("idle_a_ready", 32'(bus.a_ready), 32'h1);
    chk("idle_m_ready", 32'(bus.m_ready), 32'h1);
    $display("reset: ready low, port idle");

    single_src("single");

    // Simultaneous, different registers, last_grant = A -> M first.
    bus.a_valid = 1'b1; bus.a_addr = 2'd1; bus.a_data = 8'h11;
    bus.m_valid = 1'b1; bus.m_addr = 2'd3; bus.m_data = 8'h33;
    step();
    bus.a_valid = 1'b0; bus.m_valid = 1'b0;
    chk("sim_m_ready", 32'(bus.m_ready),   32'h1);
    chk("sim_a_ready", 32'(bus.a_ready),   32'h0);
    chk("sim_busy",    32'(bus.busy_mask), 32'hA);
    step();
    chk("sim_w1_en",   32'(bus.rf_w_en),   32'h1);
    chk("sim_w1_addr", 32'(bus.rf_w_addr), 32'h3);
    chk("sim_w1_data", 32'(bus.rf_w_data), 32'h33);
    step();
    chk("sim_w2_en",   32'(bus.rf_w_en),   32'h1);
    chk("sim_w2_addr", 32'(bus.rf_w_addr), 32'h1);
    chk("sim_w2_data", 32'(bus.rf_w_data), 32'h11);
    step();
    chk("sim_idle_en", 32'(bus.rf_w_en),   32'h0);
    $display("simultaneous: r3=33 then r1=11");

    // Same register: M(2,AA) then A(2,BB) one cycle later.
    bus.m_valid = 1'b1; bus.m_addr = 2'd2; bus.m_data = 8'hAA;
    step();
    bus.m_valid = 1'b0;
    bus.a_valid = 1'b1; bus.a_addr = 2'd2; bus.a_data = 8'hBB;
    chk("same_busy0", 32'(bus.busy_mask), 32'h4);
    step();
    bus.a_valid = 1'b0;
    chk("same_w1_addr", 32'(bus.rf_w_addr), 32'h2);
    chk("same_w1_data", 32'(bus.rf_w_data), 32'hAA);
    chk("same_busy1",   32'(bus.busy_mask), 32'h4);
    step();
    chk("same_w2_en",   32'(bus.rf_w_en),   32'h1);
    chk("same_w2_data", 32'(bus.rf_w_data), 32'hBB);
    chk("same_busy2",   32'(bus.busy_mask), 32'h4);
    step();
    chk("same_en_off",  32'(bus.rf_w_en),   32'h0);
    chk("same_busy3",   32'(bus.busy_mask), 32'h0);
    $display("same-reg: r2=AA then r2=BB");

    // Age beats round robin: last_grant = M, both load r0 together -> M older.
    bus.m_valid = 1'b1; bus.m_addr = 2'd3; bus.m_data = 8'hD0;
    step();
    bus.a_valid = 1'b1; bus.a_addr = 2'd0; bus.a_data = 8'hC1;
    bus.m_valid = 1'b1; bus.m_addr = 2'd0; bus.m_data = 8'hC2;
    step();
    bus.a_valid = 1'b0; bus.m_valid = 1'b0;
    chk("age_w0_data", 32'(bus.rf_w_data), 32'hD0);
    chk("age_m_ready", 32'(bus.m_ready),   32'h1);
    chk("age_a_ready", 32'(bus.a_ready),   32'h0);
    step();
    chk("age_w1_addr", 32'(bus.rf_w_addr), 32'h0);
    chk("age_w1_data", 32'(bus.rf_w_data), 32'hC2);
    step();
    chk("age_w2_data", 32'(bus.rf_w_data), 32'hC1);
    step();
    chk("age_en_off",  32'(bus.rf_w_en),   32'h0);
    $display("age: r0=C2 (M older) then r0=C1");

    // Saturation: both valid for 10 cycles; writes alternate M0,A0,M1,A1,...
    a_cnt = 8'd0; m_cnt = 8'd0; wr = 0;
    for (int c = 0; c < 12; c++) begin
      bus.a_valid = (c < 10); bus.a_addr = 2'd1; bus.a_data = 8'h10 + a_cnt;
      bus.m_valid = (c < 10); bus.m_addr = 2'd2; bus.m_data = 8'h80 + m_cnt;
      acc_a = bus.a_valid && bus.a_ready;
      acc_m = bus.m_valid && bus.m_ready;
      step();
      if (acc_a) a_cnt++;
      if (acc_m) m_cnt++;
      if (c == 0) begin
        chk("sat_first_en", 32'(bus.rf_w_en), 32'h0);
      end else begin
        chk("sat_en", 32'(bus.rf_w_en), 32'h1);
        if (wr % 2 == 0) begin
          chk("sat_addr", 32'(bus.rf_w_addr), 32'h2);
          chk("sat_data", 32'(bus.rf_w_data), 32'(8'h80 + 8'(wr / 2)));
        end else begin
          chk("sat_addr", 32'(bus.rf_w_addr), 32'h1);
          chk("sat_data", 32'(bus.rf_w_data), 32'(8'h10 + 8'(wr / 2)));
        end
        $display("sat write %0d: r%0d=%02h", wr, bus.rf_w_addr, bus.rf_w_data);
        wr++;
      end
    end
    chk("sat_a_accepts", 32'(a_cnt), 32'd5);
    chk("sat_m_accepts", 32'(m_cnt), 32'd6);
    step();
    chk("sat_en_off", 32'(bus.rf_w_en),   32'h0);
    chk("sat_busy0",  32'(bus.busy_mask), 32'h0);

    // Reset mid-operation with both buffers full.
    bus.a_valid = 1'b1; bus.a_addr = 2'd1; bus.a_data = 8'hEE;
    bus.m_valid = 1'b1; bus.m_addr = 2'd2; bus.m_data = 8'hFF;
    step();
    bus.a_valid = 1'b0; bus.m_valid = 1'b0;
    chk("mid_busy_full", 32'(bus.busy_mask), 32'h6);
    rst = 1'b1;
    #1;
    chk("mid_a_ready", 32'(bus.a_ready), 32'h0);
    chk("mid_m_ready", 32'(bus.m_ready), 32'h0);
    step();
    rst = 1'b0;
    chk("mid_en0",   32'(bus.rf_w_en),   32'h0);
    chk("mid_busy0", 32'(bus.busy_mask), 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("mid_en_after",   32'(bus.rf_w_en),   32'h0);
      chk("mid_busy_after", 32'(bus.busy_mask), 32'h0);
    end
    $display("mid-reset: buffered writes discarded");
    single_src("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
